// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes,
// FSM state type and the alignment helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } lsu_state_t;

    // funct3[1:0] carries the access size for every legal encoding.
    function automatic logic is_misaligned(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic r;
        unique case (f3[1:0])
            2'b01:   r = off[0];
            2'b10:   r = |off;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Core request / response and data-memory bus of the LSU.
// slave: the LSU side; master: core plus memory (testbench).
interface lsu_rmw_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic [31:0]       load_data;
    logic              fault;
    logic              fault_sticky;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_rd,
        output stall, load_data, fault, fault_sticky,
        output mem_we, mem_addr, mem_wd
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_rd,
        input  stall, load_data, fault, fault_sticky,
        input  mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/lsu_rmw_align.sv
// Byte/halfword lane logic: load extract + extend, store merge.
// Ports: funct3_i, off_i, rd_i, wdata_i -> ld_o, st_o.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rd_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_o,
    output logic [31:0] st_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_i[7:0];
        case (off_i)
            2'd0:    byte_sel = rd_i[7:0];
            2'd1:    byte_sel = rd_i[15:8];
            2'd2:    byte_sel = rd_i[23:16];
            default: byte_sel = rd_i[31:24];
        endcase
        half_sel = off_i[1] ? rd_i[31:16] : rd_i[15:0];
    end

    always_comb begin
        ld_o = 32'h0;
        case (funct3_i)
            F3_B:    ld_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ld_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    ld_o = rd_i;
            F3_BU:   ld_o = {24'h0, byte_sel};
            F3_HU:   ld_o = {16'h0, half_sel};
            default: ld_o = 32'h0;
        endcase
    end

    // Sub-word stores overwrite one lane of the old word.
    always_comb begin
        st_o = wdata_i;
        case (funct3_i)
            F3_B: begin
                st_o = rd_i;
                case (off_i)
                    2'd0:    st_o[7:0]   = wdata_i[7:0];
                    2'd1:    st_o[15:8]  = wdata_i[7:0];
                    2'd2:    st_o[23:16] = wdata_i[7:0];
                    default: st_o[31:24] = wdata_i[7:0];
                endcase
            end
            F3_H: begin
                st_o = rd_i;
                if (off_i[1]) st_o[31:16] = wdata_i[15:0];
                else          st_o[15:0]  = wdata_i[15:0];
            end
            default: st_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit: loads and SW in one cycle, SB/SH as read-modify-write.
// Ports: clk, rst_n, bus (lsu_rmw_if.slave: request, response, memory).
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 128,
    parameter int ADDR_W    = 32
) (
    input logic        clk,
    input logic        rst_n,
    lsu_rmw_if.slave   bus
);

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_WORDS * 4);

    lsu_state_t  state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] waddr_q, waddr_d;
    logic        sticky_q;

    logic        idle;
    logic        act;
    logic        f3_ld_ok;
    logic        f3_st_ok;
    logic        illegal;
    logic        misal;
    logic        oor;
    logic        flt;
    logic        go;
    logic        do_sw;
    logic        do_sub;
    logic        do_ld;
    logic [31:0] req_word;
    logic [31:0] ld_ext;
    logic [31:0] st_merge;

    lsu_align u_align (
        .funct3_i (bus.req_funct3),
        .off_i    (bus.req_addr[1:0]),
        .rd_i     (bus.mem_rd),
        .wdata_i  (bus.req_wdata),
        .ld_o     (ld_ext),
        .st_o     (st_merge)
    );

    // Request decode; requests are ignored while WRITE is in flight.
    always_comb begin
        idle     = (state_q == IDLE);
        act      = bus.req_valid & idle;
        f3_ld_ok = (bus.req_funct3 == F3_B)  ||
                   (bus.req_funct3 == F3_H)  ||
                   (bus.req_funct3 == F3_W)  ||
                   (bus.req_funct3 == F3_BU) ||
                   (bus.req_funct3 == F3_HU);
        f3_st_ok = (bus.req_funct3 == F3_B)  ||
                   (bus.req_funct3 == F3_H)  ||
                   (bus.req_funct3 == F3_W);
        illegal  = bus.req_we ? !f3_st_ok : !f3_ld_ok;
        misal    = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
        oor      = (bus.req_addr >= LIMIT);
        flt      = act & (illegal | misal | oor);
        go       = act & !flt;
        do_ld    = go & !bus.req_we;
        do_sw    = go & bus.req_we & (bus.req_funct3 == F3_W);
        do_sub   = go & bus.req_we & (bus.req_funct3 != F3_W);
        req_word = 32'(bus.req_addr) & ~32'h3;
    end

    always_comb begin
        state_d = state_q;
        merge_d = merge_q;
        waddr_d = waddr_q;
        unique case (state_q)
            IDLE: begin
                if (do_sub) begin
                    state_d = WRITE;
                    merge_d = st_merge;
                    waddr_d = req_word;
                end
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            merge_q  <= 32'h0;
            waddr_q  <= 32'h0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            merge_q  <= merge_d;
            waddr_q  <= waddr_d;
            sticky_q <= sticky_q | flt;
        end
    end

    // rst_n gating keeps the memory quiet for the whole reset pulse.
    always_comb begin
        bus.fault        = flt;
        bus.fault_sticky = sticky_q;
        bus.stall        = rst_n & do_sub;
        bus.mem_we       = rst_n & (do_sw | !idle);
        bus.mem_addr     = idle ? req_word : waddr_q;
        bus.mem_wd       = idle ? bus.req_wdata : merge_q;
        bus.load_data    = do_ld ? ld_ext : 32'h0;
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: vector table with scoreboard,
// plus hand sequences for read-modify-write and reset corners.
module tb_lsu_rmw;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_rmw_if #(.ADDR_W(32)) bus ();

    lsu_rmw #(.MEM_WORDS(128), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:127];
    always @(posedge clk)
        if (bus.mem_we) mem[bus.mem_addr[8:2]] <= bus.mem_wd;
    assign bus.mem_rd = mem[bus.mem_addr[8:2]];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
    endtask

    typedef struct {
        logic        v;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ld;
        logic        flt;
        logic        stl;
        logic        mwe;
        logic        stk;
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] ld;
        logic [31:0] wd;
        logic [31:0] ma;
        logic        ck_ma;
        logic        flt;
        logic        stl;
        logic        mwe;
        logic        stk;
    } exp_t;

    exp_t sb[$];
    vec_t tv[18];

    task automatic store_cycles(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output int cyc);
        bit done;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, f3, a, wd);
        cyc = 0;
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            cyc++;
            if (!bus.stall) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL store_timeout: stall still %0b want 0", bus.stall);
        end
    endtask

    initial begin
        int c1, c2;
        exp_t e;

        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        mem[5] = 32'hCAFEF00D;

        tv[0]  = '{1,0,F3_B, 32'h13,0,32'hFFFFFF88,0,0,0,0};
        tv[1]  = '{1,0,F3_BU,32'h13,0,32'h00000088,0,0,0,0};
        tv[2]  = '{1,0,F3_H, 32'h12,0,32'hFFFF8899,0,0,0,0};
        tv[3]  = '{1,0,F3_HU,32'h10,0,32'h0000AABB,0,0,0,0};
        tv[4]  = '{1,0,F3_W, 32'h10,0,32'h8899AABB,0,0,0,0};
        tv[5]  = '{1,0,F3_B, 32'h10,0,32'hFFFFFFBB,0,0,0,0};
        tv[6]  = '{1,0,F3_BU,32'h11,0,32'h000000AA,0,0,0,0};
        tv[7]  = '{1,1,F3_W, 32'h20,32'hDEADBEEF,0,0,0,1,0};
        tv[8]  = '{1,0,F3_W, 32'h20,0,32'hDEADBEEF,0,0,0,0};
        tv[9]  = '{0,0,F3_W, 32'h10,0,32'h0,0,0,0,0};
        tv[10] = '{1,0,F3_H, 32'h22,0,32'hFFFFDEAD,0,0,0,0};
        tv[11] = '{1,0,F3_W, 32'h22,0,32'h0,1,0,0,0};
        tv[12] = '{1,1,F3_H, 32'h21,32'h55,32'h0,1,0,0,1};
        tv[13] = '{1,0,3'b011,32'h10,0,32'h0,1,0,0,1};
        tv[14] = '{1,0,F3_W, 32'h200,0,32'h0,1,0,0,1};
        tv[15] = '{1,1,3'b100,32'h10,32'h1,32'h0,1,0,0,1};
        tv[16] = '{1,1,F3_W, 32'h1FC,32'h01020304,0,0,0,1,1};
        tv[17] = '{1,0,F3_W, 32'h1FC,0,32'h01020304,0,0,0,1};

        // reset state, with a legal SW presented
        drive(1'b1, 1'b1, F3_W, 32'h40, 32'h11111111);
        #2;
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_sticky", 32'(bus.fault_sticky), 32'h0);
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // table vectors through the scoreboard
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            drive(tv[i].v, tv[i].we, tv[i].f3, tv[i].a, tv[i].wd);
            e.nm    = $sformatf("vec%0d", i);
            e.ld    = tv[i].ld;
            e.wd    = tv[i].wd;
            e.ma    = tv[i].a & ~32'h3;
            e.ck_ma = tv[i].v & !tv[i].flt;
            e.flt   = tv[i].flt;
            e.stl   = tv[i].stl;
            e.mwe   = tv[i].mwe;
            e.stk   = tv[i].stk;
            sb.push_back(e);
            @(negedge clk);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: got 0 entries want 1");
            end else begin
                e = sb.pop_front();
                chk({e.nm, "_ld"}, bus.load_data, e.ld);
                chk({e.nm, "_flt"}, 32'(bus.fault), 32'(e.flt));
                chk({e.nm, "_stl"}, 32'(bus.stall), 32'(e.stl));
                chk({e.nm, "_we"}, 32'(bus.mem_we), 32'(e.mwe));
                chk({e.nm, "_stk"}, 32'(bus.fault_sticky), 32'(e.stk));
                if (e.ck_ma) chk({e.nm, "_ma"}, bus.mem_addr, e.ma);
                if (e.mwe) chk({e.nm, "_wd"}, bus.mem_wd, e.wd);
            end
        end

        // SB read-modify-write on word 0x10
        @(posedge clk); #1;
        drive(1'b1, 1'b1, F3_B, 32'h11, 32'h000000CC);
        @(negedge clk);
        chk("sb_c1_stall", 32'(bus.stall), 32'h1);
        chk("sb_c1_we", 32'(bus.mem_we), 32'h0);
        chk("sb_c1_addr", bus.mem_addr, 32'h10);
        @(negedge clk);
        chk("sb_c2_we", 32'(bus.mem_we), 32'h1);
        chk("sb_c2_wd", bus.mem_wd, 32'h8899CCBB);
        chk("sb_c2_stall", 32'(bus.stall), 32'h0);
        chk("sb_c2_addr", bus.mem_addr, 32'h10);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        @(negedge clk);
        chk("sb_lw", bus.load_data, 32'h8899CCBB);

        // back-to-back sub-word stores on word 0x30
        store_cycles(F3_H, 32'h30, 32'h0000BEEF, c1);
        store_cycles(F3_B, 32'h33, 32'h0000007A, c2);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        chk("b2b_cycles", 32'(c1 + c2), 32'd4);
        chk("b2b_word", mem[12], 32'h7A00BEEF);

        // reset pulse during WRITE of SH 0x14
        @(posedge clk); #1;
        drive(1'b1, 1'b1, F3_H, 32'h14, 32'h00001234);
        @(negedge clk);
        chk("rw_stall", 32'(bus.stall), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rw_rst_we", 32'(bus.mem_we), 32'h0);
        chk("rw_rst_stall", 32'(bus.stall), 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rw_sticky", 32'(bus.fault_sticky), 32'h0);
        chk("rw_word", mem[5], 32'hCAFEF00D);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, F3_W, 32'h14, 32'h0);
        @(negedge clk);
        chk("rw_lw", bus.load_data, 32'hCAFEF00D);
        chk("rw_idle_stall", 32'(bus.stall), 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit between the single-cycle core's ALU result and the word-wide data memory.
- Translates RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into whole-word memory accesses.
- Data memory has word write-enable only, so byte and halfword stores use a 2-cycle read-modify-write sequence; the core is stalled during that sequence.
- Loads and SW complete in the request cycle. Misaligned, illegal and out-of-range accesses are suppressed and flagged.

Parameters:
- MEM_WORDS, 128: data memory depth in 32-bit words; byte addresses >= MEM_WORDS*4 are out of range.
- ADDR_W, 32: request address width.

Ports:
- clk          in   1       system clock, rising edge
- rst_n        in   1       asynchronous active-low reset
- req_valid    in   1       memory instruction in current cycle
- req_we       in   1       1 = store, 0 = load
- req_funct3   in   3       instruction funct3
- req_addr     in   ADDR_W  byte address from ALU
- req_wdata    in   32      store data (rs2)
- stall        out  1       core must hold PC and request stable
- load_data    out  32      extended load result, valid when not stalled
- fault        out  1       current request misaligned, illegal or out of range (combinational)
- fault_sticky out  1       set on any fault; cleared only by reset
- mem_we       out  1       to data memory WE
- mem_addr     out  32      to data memory A; bits [1:0] always 0
- mem_wd       out  32      to data memory WD
- mem_rd       in   32      from data memory RD (asynchronous read)

Behaviour:
- Funct3 encodings:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all others are illegal.
  - Stores: 000 SB, 001 SH, 010 SW; all others are illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
- fault = req_valid & (illegal | misaligned | out-of-range). A faulted request produces mem_we=0, stall=0, load_data=0.
- States: IDLE, WRITE. Reset gives state=IDLE, fault_sticky=0, merge register=0.
- While rst_n=0, mem_we=0 and stall=0.
- IDLE, load:
  - mem_addr = {addr[31:2],2'b00}.
  - load_data selected from mem_rd by addr[1:0] (LB/LH sign-extend; LBU/LHU zero-extend).
  - Zero latency, stall=0.
- IDLE, SW: mem_we=1, mem_wd=req_wdata, stall=0 (write at this edge).
- IDLE, SB/SH:
  - mem_we=0, stall=1.
  - Merge register <= mem_rd with the byte/halfword lane selected by addr[1:0] replaced by req_wdata[7:0] or [15:0].
  - Next state WRITE.
- WRITE:
  - mem_we=1, mem_addr = word address of the held request, mem_wd = merge register, stall=0.
  - Next state IDLE.
  - Request inputs are ignored in this cycle; the core advances after this edge.
- req_valid=0: mem_we=0, stall=0, load_data=0, no state change.
- Back-to-back sub-word stores: each takes 2 cycles. There are no pipeline overlaps and no hazards, because the read always occurs after the prior write edge.
- Reset asserted during WRITE: write suppressed, state returns to IDLE asynchronously, merge register cleared.
- fault_sticky <= 1 at any edge where fault=1; it is never cleared by later traffic.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum lsu_state_t {IDLE, WRITE};
  - helper function is_misaligned.
- One combinational sub-module, lsu_align, provides the load lane extract/extend and the store lane merge.
- lsu_rmw holds the FSM, merge register, sticky fault and port muxing.

Test Plan:
- Preload word 0x10 = 0x8899AABB:
  - LB 0x13 -> load_data=0xFFFFFF88, stall=0.
  - LBU 0x13 -> 0x00000088.
  - LH 0x12 -> 0xFFFF8899.
  - LHU 0x10 -> 0x0000AABB.
- SB 0x11 data 0x000000CC:
  - Cycle 1: stall=1, mem_we=0, mem_addr=0x10.
  - Cycle 2: mem_we=1, mem_wd=0x8899CCBB, stall=0.
  - Following LW 0x10 -> 0x8899CCBB.
- SW 0x20 data 0xDEADBEEF -> mem_we=1 same cycle, stall=0; LW 0x20 next cycle -> 0xDEADBEEF.
- LW 0x22, then SH 0x21, then funct3=011 load -> each gives fault=1, mem_we=0, stall=0; fault_sticky=1 after the first edge and remains 1.
- SH 0x14 data 0x1234 with rst_n pulsed low during WRITE -> no memory write, word 0x14 unchanged, state IDLE, fault_sticky=0 after reset.
- Back-to-back SH 0x30 (0xBEEF) then SB 0x33 (0x7A) on word 0x30 = 0 -> 4 cycles total; final word 0x7A00BEEF.
